ysyx_22040386_mdu_seq: RTL and testbench
========================================

// Module: ysyx_22040386_mdu_seq
// PURPOSE
//  Multi-cycle multiply/divide sequencer for the EXU. It replaces the single-cycle '*', '/' and '%' operators
//  of the ALU with one shared radix-2 iterative engine: shift-add for multiply, restoring for divide.
//  Ops are taken over a valid/ready handshake; the result is held until the consumer accepts it.
//  A flush from the pipeline controller aborts any op in flight.
// PARAMETERS
//  XLEN    64   operand/result width
//  CNT_W   7    iteration counter width, must hold XLEN
// PORTS
//  clk        in   1     clock, all state updates on the rising edge
//  rst_n      in   1     asynchronous active-low reset
//  flush      in   1     synchronous abort, highest priority
//  in_valid   in   1     op request
//  in_ready   out  1     high only in IDLE
//  funct3     in   3     000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
//  word_op    in   1     RV64 *W form; legal only with funct3 000/100/101/110/111
//  src1       in   64    multiplicand / dividend
//  src2       in   64    multiplier / divisor
//  out_valid  out  1     result valid
//  out_ready  in   1     consumer accepts the result
//  result     out  64    final result
//  busy       out  1     state != IDLE
// BEHAVIOUR
//  Reset: state = IDLE; out_valid = 0; busy = 0; result = 0; counter and internal registers = 0; in_ready = 1.
//  FSM states: IDLE, CALC, DONE.
//   - IDLE -> CALC on in_valid & in_ready, for a normal op.
//   - IDLE -> DONE on in_valid & in_ready, for a special case (below).
//   - CALC -> DONE when the counter reaches N-1.
//   - DONE -> IDLE on out_valid & out_ready.
//   - Any state -> IDLE when flush = 1. A flushed op produces no output.
//   - An in_valid present in a flush cycle is not accepted.
//  Operand capture at accept:
//   - word_op = 1: use src[31:0], sign-extended for signed ops, zero-extended for divuw/remuw. N = 32.
//   - word_op = 0: N = 64.
//   - Signedness: signed ops use magnitudes. mulhsu treats src1 as signed and src2 as unsigned.
//   - Record the result sign: product sign = s1 ^ s2; quotient sign = s1 ^ s2; remainder sign = s1.
//  CALC, one iteration per cycle, N cycles total:
//   - mul: 2N-bit accumulator; if multiplier bit i = 1, add multiplicand << i.
//   - div: shift the remainder left by one and bring in the next dividend bit; trial-subtract the divisor;
//     the quotient bit is 1 if the difference is >= 0, and in that case the remainder is replaced by the difference.
//  DONE:
//   - Negate to the recorded sign.
//   - Select the output: mul takes low XLEN bits; mulh/mulhsu/mulhu take high XLEN bits.
//   - word_op = 1: result = sign-extend of bit 31 for every W op, including divuw/remuw.
//   - result and out_valid are registered and stay stable while out_valid & !out_ready.
//  Latency:
//   - Normal op: out_valid rises N+1 cycles after the accept edge.
//   - Special case: out_valid rises 1 cycle after the accept edge.
//   - Minimum op-to-op spacing is one IDLE cycle, because in_ready = 0 in DONE.
//  Special cases, resolved at accept with no iteration:
//   - Divide by zero (divisor = 0 within the op width): quotient = all ones; remainder = dividend.
//   - Signed overflow (dividend = most-negative, divisor = -1): quotient = dividend; remainder = 0.
//   - W forms test these conditions on 32-bit values, then sign-extend.
//  Other boundaries:
//   - out_ready held high in DONE: the result is consumed in that cycle, and the next state is IDLE.
//   - Asynchronous reset asserted mid-CALC: internal state clears immediately; no output.
//   - in_valid while busy: ignored. The requester must hold the request until in_ready.
// TESTING
//  mul, 7 * -3 -> result 0xFFFF_FFFF_FFFF_FFEB, out_valid 65 cycles after accept.
//  mulhu, 0xFFFF_FFFF_FFFF_FFFF * 2 -> result 0x1; mulh, -1 * -1 -> result 0x0.
//  div/rem, -7 by 2 -> quotient 0xFFFF_FFFF_FFFF_FFFD (-3), remainder 0xFFFF_FFFF_FFFF_FFFF (-1).
//  divuw, 0x8000_0000 by 1 -> 0xFFFF_FFFF_8000_0000, 33-cycle latency.
//  div, x by 0 -> all ones; div, 0x8000_0000_0000_0000 by -1 -> same value;
//   rem x by 0 -> x; each with out_valid one cycle after accept.
//  flush in CALC cycle 10 -> IDLE next cycle, out_valid stays 0; hold out_ready = 0 for 5 cycles in DONE -> result stable.

Source files
------------

// File: rtl/ysyx_22040386_mdu_seq.sv
// ysyx_22040386_mdu_seq: shared radix-2 iterative multiply/divide engine (shift-add mul, restoring div)
// with valid/ready handshakes on both sides and a synchronous flush.
module ysyx_22040386_mdu_seq #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            word_op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int H = XLEN / 2;
  localparam logic [CNT_W-1:0] LAST_W = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] LAST_D = CNT_W'(XLEN - 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [2*XLEN-1:0] a_q, a_d, acc_q, acc_d;
  logic [XLEN-1:0] b_q, b_d, result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] f_q, f_d;
  logic neg_q, neg_d, word_q, word_d, out_valid_q, out_valid_d;
  logic sx, s1en, s2en, neg1, neg2, dz, ovf, ge;
  logic [XLEN-1:0] e1, e2, m1, m2, most_neg, diff, q_fin, r_fin, sel;
  logic [XLEN:0] r_sh;
  logic [2*XLEN-1:0] p_fin;
  // W operands are sign-extended except for divuw/remuw
  assign sx       = ~(funct3[2] & funct3[0]);
  assign e1       = word_op ? {{H{src1[H-1] & sx}}, src1[H-1:0]} : src1;
  assign e2       = word_op ? {{H{src2[H-1] & sx}}, src2[H-1:0]} : src2;
  assign s1en     = funct3 == 3'b001 || funct3 == 3'b010 || funct3 == 3'b100 || funct3 == 3'b110;
  assign s2en     = funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b110;
  assign neg1     = s1en & e1[XLEN-1];
  assign neg2     = s2en & e2[XLEN-1];
  assign m1       = neg1 ? -e1 : e1;
  assign m2       = neg2 ? -e2 : e2;
  assign most_neg = word_op ? {{(H+1){1'b1}}, {(H-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
  assign dz       = funct3[2] & (e2 == '0);
  assign ovf      = funct3[2] & ~funct3[0] & (e1 == most_neg) & (&e2);
  // restoring step: the difference is only kept when it fits, so its low XLEN bits suffice
  assign r_sh     = {acc_q[XLEN-1:0], a_q[XLEN-1]};
  assign ge       = r_sh >= {1'b0, b_q};
  assign diff     = r_sh[XLEN-1:0] - b_q;
  assign p_fin    = neg_q ? -acc_q : acc_q;
  assign q_fin    = neg_q ? -a_q[XLEN-1:0] : a_q[XLEN-1:0];
  assign r_fin    = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign sel      = f_q[2] ? (f_q[1] ? r_fin : q_fin) : (f_q[1:0] == 2'b00 ? p_fin[XLEN-1:0] : p_fin[2*XLEN-1:XLEN]);
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    f_d         = f_q;
    neg_d       = neg_q;
    word_d      = word_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      cnt_d       = '0;
    end else if (state_q == IDLE) begin
      if (in_valid) begin
        f_d    = funct3;
        word_d = word_op;
        cnt_d  = '0;
        if (dz || ovf) begin
          state_d = DONE;
          neg_d   = 1'b0;
          a_d     = {{XLEN{1'b0}}, dz ? {XLEN{1'b1}} : e1};
          acc_d   = {{XLEN{1'b0}}, dz ? e1 : {XLEN{1'b0}}};
        end else begin
          state_d = CALC;
          neg_d   = (funct3[2] & funct3[1]) ? neg1 : neg1 ^ neg2;
          b_d     = m2;
          acc_d   = '0;
          a_d     = (funct3[2] & word_op) ? {{XLEN{1'b0}}, m1[H-1:0], {H{1'b0}}} : {{XLEN{1'b0}}, m1};
        end
      end
    end else if (state_q == CALC) begin
      if (f_q[2]) begin
        acc_d = {{XLEN{1'b0}}, ge ? diff : r_sh[XLEN-1:0]};
        a_d   = {a_q[2*XLEN-2:0], ge};
      end else begin
        acc_d = acc_q + (b_q[0] ? a_q : '0);
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
      end
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == (word_q ? LAST_W : LAST_D)) begin
        state_d = DONE;
        cnt_d   = '0;
      end
    end else if (!out_valid_q) begin
      out_valid_d = 1'b1;
      result_d    = word_q ? {{H{sel[H-1]}}, sel[H-1:0]} : sel;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      f_q         <= '0;
      neg_q       <= 1'b0;
      word_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      f_q         <= f_d;
      neg_q       <= neg_d;
      word_q      <= word_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end
endmodule

// File: tb/tb_ysyx_22040386_mdu_seq.sv
// tb_ysyx_22040386_mdu_seq: directed and random ops against an arithmetic reference model.
module tb_ysyx_22040386_mdu_seq;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, word_op = 1'b0, out_ready = 1'b0;
  logic [2:0] funct3 = '0;
  logic [63:0] src1 = '0, src2 = '0;
  logic in_ready, out_valid, busy;
  logic [63:0] result;
  int total = 0, bad = 0;
  ysyx_22040386_mdu_seq dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .word_op(word_op), .src1(src1), .src2(src2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] ref_model(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] pr;
    logic [63:0] r;
    logic [31:0] r32;
    int sa32, sb32;
    longint sa, sb;
    r = '0;
    if (w) begin
      sa32 = a[31:0];
      sb32 = b[31:0];
      r32 = '0;
      case (f)
        3'd0: r32 = a[31:0] * b[31:0];
        3'd4: if (sb32 == 0) r32 = '1; else if (sa32 == 32'sh8000_0000 && sb32 == -1) r32 = sa32; else r32 = sa32 / sb32;
        3'd5: if (b[31:0] == 0) r32 = '1; else r32 = a[31:0] / b[31:0];
        3'd6: if (sb32 == 0) r32 = sa32; else if (sa32 == 32'sh8000_0000 && sb32 == -1) r32 = 0; else r32 = sa32 % sb32;
        3'd7: if (b[31:0] == 0) r32 = a[31:0]; else r32 = a[31:0] % b[31:0];
        default: r32 = '0;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      sa = a;
      sb = b;
      case (f)
        3'd0: r = a * b;
        3'd1: begin pr = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); r = pr[127:64]; end
        3'd2: begin pr = $signed({{64{a[63]}}, a}) * $signed({64'd0, b}); r = pr[127:64]; end
        3'd3: begin pr = {64'd0, a} * {64'd0, b}; r = pr[127:64]; end
        3'd4: if (b == 0) r = '1; else if (a == 64'h8000_0000_0000_0000 && sb == -1) r = a; else r = sa / sb;
        3'd5: if (b == 0) r = '1; else r = a / b;
        3'd6: if (b == 0) r = a; else if (a == 64'h8000_0000_0000_0000 && sb == -1) r = 0; else r = sa % sb;
        default: if (b == 0) r = a; else r = a % b;
      endcase
    end
    return r;
  endfunction
  function automatic int ref_lat(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b);
    logic zero, ovf;
    zero = w ? (b[31:0] == 0) : (b == 0);
    ovf  = !f[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1) : (a == 64'h8000_0000_0000_0000 && b == '1));
    if (f[2] && (zero || ovf)) return 1;
    return w ? 33 : 65;
  endfunction
  // issue one op from IDLE; junk = cycles to keep a second request pending while busy
  task automatic run_op(input string tag, input logic [2:0] f, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input int hold, input int junk);
    logic [63:0] exp;
    int lat, cyc;
    exp = ref_model(f, w, a, b);
    lat = ref_lat(f, w, a, b);
    funct3 = f; word_op = w; src1 = a; src2 = b; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    funct3 = 3'd5; src1 = ~a; src2 = 64'd3; in_valid = junk > 0;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc >= junk) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk({tag, "_lat"}, 64'(cyc), 64'(lat));
    chk({tag, "_res"}, result, exp);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      chk({tag, "_hold"}, {out_valid, result[62:0]}, {1'b1, exp[62:0]});
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, "_ack"}, {62'd0, out_valid, in_ready}, 64'd1);
    out_ready = 1'b0;
  endtask
  initial begin
    logic [2:0] f;
    logic w, seen;
    logic [63:0] a, b;
    #12;
    chk("rst_state", {60'd0, out_valid, busy, in_ready, 1'b0}, 64'd2);
    chk("rst_result", result, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("mul", 3'd0, 1'b0, 64'd7, -64'sd3, 0, 0);
    run_op("mulhu", 3'd3, 1'b0, '1, 64'd2, 0, 0);
    run_op("mulh", 3'd1, 1'b0, '1, '1, 2, 0);
    run_op("div", 3'd4, 1'b0, -64'sd7, 64'd2, 0, 0);
    run_op("rem", 3'd6, 1'b0, -64'sd7, 64'd2, 0, 0);
    run_op("divuw", 3'd5, 1'b1, 64'h8000_0000, 64'd1, 0, 0);
    run_op("div0", 3'd4, 1'b0, 64'h1234_5678_9abc_def0, 64'd0, 0, 0);
    run_op("divovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 0, 0);
    run_op("rem0", 3'd6, 1'b0, 64'hdead_beef_0000_1111, 64'd0, 0, 0);
    run_op("remw0", 3'd6, 1'b1, 64'h0000_0000_8000_0001, 64'hffff_ffff_0000_0000, 0, 0);
    run_op("divwovf", 3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_ffff_ffff, 0, 0);
    run_op("mulhsu", 3'd2, 1'b0, -64'sd5, 64'hffff_ffff_ffff_fff0, 0, 0);
    run_op("hold5", 3'd7, 1'b0, 64'd1000, 64'd7, 5, 0);
    run_op("busyreq", 3'd0, 1'b0, 64'd3, 64'd4, 0, 5);
    // flush in the tenth CALC cycle, with a competing request in the flush cycle
    funct3 = 3'd0; word_op = 1'b0; src1 = 64'd5; src2 = 64'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle", {62'd0, busy, in_ready}, 64'd1);
    seen = 1'b0;
    repeat (70) begin @(posedge clk); #1; seen |= out_valid; end
    chk("flush_noout", {63'd0, seen}, 64'd0);
    // asynchronous reset in the middle of CALC
    funct3 = 3'd4; src1 = 64'd99; src2 = 64'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("arst_clear", {61'd0, out_valid, busy, in_ready}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (70) begin @(posedge clk); #1; seen |= out_valid; end
    chk("arst_noout", {63'd0, seen}, 64'd0);
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      w = (f == 3'd0 || f[2]) && $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 5))
        0: a = '0;
        1: a = '1;
        2: a = w ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
        default: a = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = '1;
        2: b = {32'd0, 32'($urandom_range(1, 9))};
        default: b = {$urandom, $urandom};
      endcase
      run_op("rnd", f, w, a, b, $urandom_range(0, 3), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
